// File: rtl/image_pkg.sv
// Shared image geometry, stream beat payload and reader state encoding.
package image_pkg;

    localparam int unsigned X_MAX       = 200;
    localparam int unsigned Y_MAX       = 200;
    localparam int unsigned PIXEL_DEPTH = 8;
    localparam int unsigned X_W         = $clog2(X_MAX);
    localparam int unsigned Y_W         = $clog2(Y_MAX);

    typedef struct packed {
        logic [PIXEL_DEPTH-1:0] data;
        logic [X_W-1:0]         x;
        logic [Y_W-1:0]         y;
        logic                   eol;
        logic                   last;
    } pix_beat_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } reader_state_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry FIFO of pixel beats between the SRAM read return and the output stream.
module pixel_skid_fifo
    import image_pkg::*;
(
    input  logic      clk,
    input  logic      n_rst,
    input  logic      push,
    input  logic      pop,
    input  logic      flush,
    input  pix_beat_t din,
    output pix_beat_t dout,
    output logic [1:0] count
);

    pix_beat_t mem [2];
    logic      wr_ptr;
    logic      rd_ptr;
    logic      do_push;
    logic      do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

endmodule

// File: rtl/conv_frame_reader.sv
// Reads a finished convolution frame from SRAM in raster order and streams it
// out over valid/ready, never issuing a read whose data could not be stored.
module conv_frame_reader
    import image_pkg::*;
(
    input  logic                   clk,
    input  logic                   n_rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [X_W-1:0]         max_x,
    input  logic [Y_W-1:0]         max_y,
    output logic [X_W:0]           x_addr_conv,
    output logic [Y_W:0]           y_addr_conv,
    output logic                   ren_conv,
    input  logic [PIXEL_DEPTH-1:0] rdat_conv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PIXEL_DEPTH-1:0] out_data,
    output logic [X_W-1:0]         out_x,
    output logic [Y_W-1:0]         out_y,
    output logic                   out_eol,
    output logic                   out_last,
    output logic                   busy,
    output logic                   done
);

    reader_state_t  state;
    logic [X_W-1:0] lim_x;
    logic [X_W-1:0] cur_x;
    logic [X_W-1:0] x_addr;
    logic [Y_W-1:0] lim_y;
    logic [Y_W-1:0] cur_y;
    logic [Y_W-1:0] y_addr;
    logic           inflight;
    pix_beat_t      tag;
    pix_beat_t      push_beat;
    pix_beat_t      head;
    logic [1:0]     fifo_count;
    logic [2:0]     occ_c;
    logic           pop_c;
    logic           kill_c;
    logic           issue_c;
    logic           row_end_c;
    logic           frame_end_c;

    // Occupancy after this edge's pop; reads stop once FIFO plus in-flight would reach two.
    assign pop_c       = out_valid && out_ready;
    assign kill_c      = abort && (state != IDLE);
    assign occ_c       = 3'(fifo_count) + 3'(inflight) - 3'(pop_c);
    assign issue_c     = (state == READ) && (occ_c < 3'd2);
    assign row_end_c   = (cur_x == lim_x);
    assign frame_end_c = row_end_c && (cur_y == lim_y);

    always_comb begin
        push_beat      = tag;
        push_beat.data = rdat_conv;
    end

    pixel_skid_fifo u_fifo (
        .clk   (clk),
        .n_rst (n_rst),
        .push  (inflight && !kill_c),
        .pop   (pop_c),
        .flush (kill_c),
        .din   (push_beat),
        .dout  (head),
        .count (fifo_count)
    );

    assign out_valid   = (fifo_count != 2'd0);
    assign out_data    = head.data;
    assign out_x       = head.x;
    assign out_y       = head.y;
    assign out_eol     = head.eol;
    assign out_last    = head.last;
    assign x_addr_conv = {1'b0, x_addr};
    assign y_addr_conv = {1'b0, y_addr};

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            lim_x    <= '0;
            lim_y    <= '0;
            cur_x    <= '0;
            cur_y    <= '0;
            x_addr   <= '0;
            y_addr   <= '0;
            tag      <= '0;
            inflight <= 1'b0;
            ren_conv <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (kill_c) begin
            state    <= IDLE;
            inflight <= 1'b0;
            ren_conv <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            ren_conv <= issue_c;
            inflight <= issue_c;
            done     <= 1'b0;
            // Beat tags travel with the read so the FIFO never has to recompute position.
            if (issue_c) begin
                x_addr <= cur_x;
                y_addr <= cur_y;
                tag    <= '{data: '0, x: cur_x, y: cur_y, eol: row_end_c, last: frame_end_c};
                if (row_end_c) begin
                    cur_x <= '0;
                    cur_y <= cur_y + Y_W'(1);
                end else begin
                    cur_x <= cur_x + X_W'(1);
                end
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= READ;
                        busy  <= 1'b1;
                        lim_x <= max_x;
                        lim_y <= max_y;
                        cur_x <= '0;
                        cur_y <= '0;
                    end
                end
                READ: begin
                    if (issue_c && frame_end_c) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop_c && out_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_frame_reader.sv
// Directed bench for conv_frame_reader with a combinational SRAM holding 16*y + x.
module tb_conv_frame_reader;
    import image_pkg::*;

    logic                   clk = 1'b0;
    logic                   n_rst;
    logic                   start;
    logic                   abort;
    logic [X_W-1:0]         max_x;
    logic [Y_W-1:0]         max_y;
    logic [X_W:0]           x_addr_conv;
    logic [Y_W:0]           y_addr_conv;
    logic                   ren_conv;
    logic [PIXEL_DEPTH-1:0] rdat_conv;
    logic                   out_valid;
    logic                   out_ready;
    logic [PIXEL_DEPTH-1:0] out_data;
    logic [X_W-1:0]         out_x;
    logic [Y_W-1:0]         out_y;
    logic                   out_eol;
    logic                   out_last;
    logic                   busy;
    logic                   done;

    int checks = 0;
    int errors = 0;

    pix_beat_t beats[$];
    int issued, hs_cnt, done_cnt, done_cyc, last_hs_cyc, first_valid, first_ren;
    int max_out, stall_err, timed_out, post_ren, post_valid, post_busy;

    always #5 clk = ~clk;

    assign rdat_conv = PIXEL_DEPTH'(int'(y_addr_conv) * 16 + int'(x_addr_conv));

    conv_frame_reader dut (
        .clk         (clk),
        .n_rst       (n_rst),
        .start       (start),
        .abort       (abort),
        .max_x       (max_x),
        .max_y       (max_y),
        .x_addr_conv (x_addr_conv),
        .y_addr_conv (y_addr_conv),
        .ren_conv    (ren_conv),
        .rdat_conv   (rdat_conv),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_eol     (out_eol),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done)
    );

    // Expected raster beats compared against the recorded stream; returns the mismatch count.
    function automatic int seq_errors(input int mx, input int my, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            int x = i % (mx + 1);
            int y = i / (mx + 1);
            pix_beat_t e;
            e.data = PIXEL_DEPTH'(16 * y + x);
            e.x    = X_W'(x);
            e.y    = Y_W'(y);
            e.eol  = (x == mx);
            e.last = (x == mx) && (y == my);
            if (i >= beats.size() || beats[i] !== e) bad++;
        end
        return bad;
    endfunction

    // mode 0: ready high; 1: ready 1,0,0,1; 2: ready high plus stray start pulses.
    task automatic run_frame(input int mx, input int my, input int mode,
                             input int abort_after, input int budget);
        pix_beat_t cur;
        pix_beat_t prev = '0;
        bit stall_prev = 0;
        bit aborted = 0;
        bit finished = 0;
        int abort_cyc = 0;
        int tail = 0;
        bit after_end;
        beats.delete();
        issued = 0; hs_cnt = 0; done_cnt = 0; done_cyc = -1; last_hs_cyc = -1;
        first_valid = -1; first_ren = -1; max_out = 0; stall_err = 0; timed_out = 0;
        post_ren = 0; post_valid = 0; post_busy = 0;
        @(negedge clk);
        max_x = X_W'(mx);
        max_y = Y_W'(my);
        out_ready = 1'b1;
        abort = 1'b0;
        start = 1'b1;
        for (int cyc = 0; cyc < budget && !finished; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            if (mode == 2 && cyc == 3) begin
                start = 1'b1;
                max_x = '0;
                max_y = '0;
            end
            if (mode == 2 && done) start = 1'b1;
            out_ready = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
            abort = 1'b0;
            if (abort_after > 0 && !aborted && hs_cnt == abort_after) begin
                abort = 1'b1;
                aborted = 1;
                abort_cyc = cyc;
                out_ready = 1'b0;
            end
            after_end = (aborted && cyc > abort_cyc) || (done_cnt > 0 && cyc > done_cyc);
            if (ren_conv) begin
                issued++;
                if (first_ren < 0) first_ren = cyc;
                if (after_end) post_ren++;
            end
            if (issued - hs_cnt > max_out) max_out = issued - hs_cnt;
            cur = {out_data, out_x, out_y, out_eol, out_last};
            if (stall_prev && (!out_valid || cur !== prev)) stall_err++;
            if (out_valid && first_valid < 0) first_valid = cyc;
            if (after_end && out_valid) post_valid++;
            if (after_end && busy) post_busy++;
            if (out_valid && out_ready) begin
                beats.push_back(cur);
                hs_cnt++;
                last_hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            stall_prev = out_valid && !out_ready;
            prev = cur;
            if (done_cnt > 0 || aborted) tail++;
            if (tail == 6) finished = 1;
        end
        start = 1'b0;
        abort = 1'b0;
        if (!finished) timed_out = 1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({x_addr_conv, y_addr_conv, ren_conv, out_valid, out_data, out_x, out_y,
             out_eol, out_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got nonzero output (busy=%0b ren=%0b valid=%0b)",
                     busy, ren_conv, out_valid);
        end
        n_rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, ren_conv, out_valid, done} !== 4'b0000) begin
            errors++;
            $display("FAIL idle_after_reset: got busy/ren/valid/done=%b expected 0000",
                     {busy, ren_conv, out_valid, done});
        end
    endtask

    task automatic test_frame_4x3();
        run_frame(3, 2, 0, 0, 100);
        checks++;
        if (timed_out !== 0) begin errors++; $display("FAIL f43_timeout: frame did not complete"); end
        checks++;
        if (beats.size() !== 12) begin errors++; $display("FAIL f43_count: got %0d expected 12", beats.size()); end
        checks++;
        if (seq_errors(3, 2, 12) !== 0) begin errors++; $display("FAIL f43_seq: %0d bad beats expected 0", seq_errors(3, 2, 12)); end
        checks++;
        if (first_ren !== 1) begin errors++; $display("FAIL f43_ren_latency: got %0d expected 1", first_ren); end
        checks++;
        if (first_valid !== 2) begin errors++; $display("FAIL f43_valid_latency: got %0d expected 2", first_valid); end
        checks++;
        if (last_hs_cyc !== 13) begin errors++; $display("FAIL f43_throughput: last beat cycle %0d expected 13", last_hs_cyc); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL f43_done_count: got %0d expected 1", done_cnt); end
        checks++;
        if (done_cyc !== last_hs_cyc + 1) begin errors++; $display("FAIL f43_done_timing: got %0d expected %0d", done_cyc, last_hs_cyc + 1); end
        checks++;
        if (post_busy !== 0) begin errors++; $display("FAIL f43_busy_after: got %0d busy cycles expected 0", post_busy); end
    endtask

    task automatic test_backpressure();
        run_frame(3, 2, 1, 0, 200);
        checks++;
        if (beats.size() !== 12 || timed_out !== 0) begin errors++; $display("FAIL bp_count: got %0d beats timeout=%0d expected 12 and 0", beats.size(), timed_out); end
        checks++;
        if (seq_errors(3, 2, 12) !== 0) begin errors++; $display("FAIL bp_seq: %0d bad beats expected 0", seq_errors(3, 2, 12)); end
        checks++;
        if (stall_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_err); end
        checks++;
        if (max_out !== 2) begin errors++; $display("FAIL bp_outstanding: max outstanding %0d expected 2", max_out); end
        checks++;
        if (done_cnt !== 1) begin errors++; $display("FAIL bp_done: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_degenerate();
        pix_beat_t exp_beat;
        exp_beat = '{data: 8'h00, x: '0, y: '0, eol: 1'b1, last: 1'b1};
        run_frame(0, 0, 0, 0, 50);
        checks++;
        if (beats.size() !== 1) begin errors++; $display("FAIL deg_count: got %0d expected 1", beats.size()); end
        checks++;
        if (beats.size() < 1 || beats[0] !== exp_beat) begin errors++; $display("FAIL deg_beat: got %h expected %h", (beats.size() > 0) ? beats[0] : '0, exp_beat); end
        checks++;
        if (done_cnt !== 1 || post_busy !== 0) begin errors++; $display("FAIL deg_done: done=%0d busy_after=%0d expected 1 and 0", done_cnt, post_busy); end
    endtask

    task automatic test_abort();
        run_frame(3, 2, 0, 5, 100);
        checks++;
        if (beats.size() !== 5) begin errors++; $display("FAIL abort_count: got %0d expected 5", beats.size()); end
        checks++;
        if (done_cnt !== 0) begin errors++; $display("FAIL abort_done: got %0d pulses expected 0", done_cnt); end
        checks++;
        if (post_ren !== 0 || post_valid !== 0 || post_busy !== 0) begin
            errors++;
            $display("FAIL abort_quiet: ren=%0d valid=%0d busy=%0d expected 0 0 0", post_ren, post_valid, post_busy);
        end
        run_frame(3, 2, 0, 0, 100);
        checks++;
        if (beats.size() !== 12 || seq_errors(3, 2, 12) !== 0) begin
            errors++;
            $display("FAIL abort_restart: got %0d beats with %0d bad expected 12 and 0", beats.size(), seq_errors(3, 2, 12));
        end
    endtask

    task automatic test_start_ignored();
        run_frame(3, 2, 2, 0, 100);
        checks++;
        if (beats.size() !== 12 || seq_errors(3, 2, 12) !== 0) begin
            errors++;
            $display("FAIL stray_start_seq: got %0d beats with %0d bad expected 12 and 0", beats.size(), seq_errors(3, 2, 12));
        end
        checks++;
        if (done_cnt !== 1 || post_ren !== 0 || post_busy !== 0) begin
            errors++;
            $display("FAIL stray_start_after: done=%0d ren=%0d busy=%0d expected 1 0 0", done_cnt, post_ren, post_busy);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        max_x = X_W'(3);
        max_y = Y_W'(2);
        out_ready = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, out_valid} !== 2'b11) begin errors++; $display("FAIL rst_mid_pre: busy/valid=%b expected 11", {busy, out_valid}); end
        #2 n_rst = 1'b0;
        #1;
        checks++;
        if ({x_addr_conv, y_addr_conv, ren_conv, out_valid, out_data, out_x, out_y,
             out_eol, out_last, busy, done} !== '0) begin
            errors++;
            $display("FAIL rst_mid_zero: busy=%0b ren=%0b valid=%0b data=%h expected all 0",
                     busy, ren_conv, out_valid, out_data);
        end
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, ren_conv} !== 3'b000) begin errors++; $display("FAIL rst_mid_after: busy/done/ren=%b expected 000", {busy, done, ren_conv}); end
    endtask

    task automatic test_full_frame();
        pix_beat_t exp_last;
        exp_last = '{data: PIXEL_DEPTH'(16 * 199 + 199), x: X_W'(199), y: Y_W'(199), eol: 1'b1, last: 1'b1};
        run_frame(199, 199, 0, 0, 41000);
        checks++;
        if (beats.size() !== 40000 || timed_out !== 0) begin errors++; $display("FAIL full_count: got %0d timeout=%0d expected 40000 and 0", beats.size(), timed_out); end
        checks++;
        if (beats.size() < 1 || beats[beats.size() - 1] !== exp_last) begin
            errors++;
            $display("FAIL full_last: got %h expected %h", (beats.size() > 0) ? beats[beats.size() - 1] : '0, exp_last);
        end
        checks++;
        if (seq_errors(199, 199, 40000) !== 0) begin errors++; $display("FAIL full_seq: %0d bad beats expected 0", seq_errors(199, 199, 40000)); end
        checks++;
        if (done_cyc - first_valid !== 40000 || done_cnt !== 1) begin
            errors++;
            $display("FAIL full_done: done %0d cycles after first valid (pulses %0d) expected 40000 and 1", done_cyc - first_valid, done_cnt);
        end
    endtask

    initial begin
        n_rst = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        out_ready = 1'b0;
        max_x = '0;
        max_y = '0;
        test_reset();
        test_frame_4x3();
        test_backpressure();
        test_degenerate();
        test_abort();
        test_start_ignored();
        test_reset_mid();
        test_full_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
